// File: rtl/maze_pkg.sv
// Shared types and constants for the maze player-movement logic.
// Directions are encoded in round-robin order so "next" is a 2-bit increment.
package maze_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int SCREEN_W        = 640;
    localparam int SCREEN_H        = 480;
    localparam int DEF_STEP        = 10;
    localparam int DEF_SIZE        = 15;
    localparam int DEF_START_X     = 55;
    localparam int DEF_START_Y     = 55;
    localparam int DEF_CHK_TIMEOUT = 15;

    // First pending direction at or after ptr, wrapping; ptr when nothing is pending.
    function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] ptr);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       hit;
        pick = ptr;
        hit  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!hit && pend[idx]) begin
                pick = idx;
                hit  = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer for a raw push button followed by a rising-edge pulse.
// The pulse is combinational from the synchronized level, one cycle wide.
module btn_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            prev_reg <= 1'b0;
        end else begin
            meta_reg <= btn;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign rise = sync_reg & ~prev_reg;

endmodule

// File: rtl/player_move_ctrl.sv
// Sequences player-square movement: captures button requests, grants one per frame
// round-robin, bounds-checks the candidate and confirms it with the maze checker.
module player_move_ctrl
    import maze_pkg::*;
#(
    parameter int STEP        = DEF_STEP,
    parameter int SIZE        = DEF_SIZE,
    parameter int START_X     = DEF_START_X,
    parameter int START_Y     = DEF_START_Y,
    parameter int X_MAX       = SCREEN_W - 1,
    parameter int Y_MAX       = SCREEN_H - 1,
    parameter int CHK_TIMEOUT = DEF_CHK_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic       chk_valid,
    output logic [9:0] chk_left,
    output logic [9:0] chk_right,
    output logic [9:0] chk_top,
    output logic [9:0] chk_bottom,
    input  logic       chk_done,
    input  logic       chk_ok,
    output logic [9:0] sq_left,
    output logic [9:0] sq_right,
    output logic [9:0] sq_top,
    output logic [9:0] sq_bottom,
    output logic       move_ok,
    output logic       move_blocked,
    output logic       busy
);

    localparam int TW = (CHK_TIMEOUT > 1) ? $clog2(CHK_TIMEOUT) : 1;
    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [10:0] XMAX11 = 11'(X_MAX);
    localparam logic [10:0] YMAX11 = 11'(Y_MAX);
    localparam logic [9:0]  RST_L  = 10'(START_X);
    localparam logic [9:0]  RST_R  = 10'(START_X + SIZE);
    localparam logic [9:0]  RST_T  = 10'(START_Y);
    localparam logic [9:0]  RST_B  = 10'(START_Y + SIZE);

    logic [3:0]    btn_vec;
    logic [3:0]    rise;
    logic [3:0]    pend_reg;
    logic [3:0]    clr_mask;
    dir_t          ptr_reg;
    state_t        state_reg;
    logic [TW-1:0] tmo_cnt_reg;
    logic [1:0]    grant;
    logic [10:0]   cand_left;
    logic [10:0]   cand_right;
    logic [10:0]   cand_top;
    logic [10:0]   cand_bottom;
    logic          out_of_bounds;

    assign btn_vec = {btn_left, btn_down, btn_right, btn_up};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
        btn_edge_sync u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .btn  (btn_vec[gi]),
            .rise (rise[gi])
        );
    end

    assign grant    = rr_pick(pend_reg, ptr_reg);
    assign clr_mask = (state_reg == ARB) ? (4'b0001 << grant) : 4'b0000;

    // 11-bit arithmetic: an underflow shows up in bit 10 instead of wrapping.
    always_comb begin
        cand_left   = {1'b0, sq_left};
        cand_right  = {1'b0, sq_right};
        cand_top    = {1'b0, sq_top};
        cand_bottom = {1'b0, sq_bottom};
        case (dir_t'(grant))
            UP: begin
                cand_top    = cand_top - STEP11;
                cand_bottom = cand_bottom - STEP11;
            end
            DOWN: begin
                cand_top    = cand_top + STEP11;
                cand_bottom = cand_bottom + STEP11;
            end
            LEFT: begin
                cand_left   = cand_left - STEP11;
                cand_right  = cand_right - STEP11;
            end
            default: begin
                cand_left   = cand_left + STEP11;
                cand_right  = cand_right + STEP11;
            end
        endcase
    end

    assign out_of_bounds = cand_left[10] | cand_top[10] |
                           (cand_right > XMAX11) | (cand_bottom > YMAX11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= UP;
            pend_reg     <= 4'b0000;
            tmo_cnt_reg  <= '0;
            chk_valid    <= 1'b0;
            chk_left     <= RST_L;
            chk_right    <= RST_R;
            chk_top      <= RST_T;
            chk_bottom   <= RST_B;
            sq_left      <= RST_L;
            sq_right     <= RST_R;
            sq_top       <= RST_T;
            sq_bottom    <= RST_B;
            move_ok      <= 1'b0;
            move_blocked <= 1'b0;
            busy         <= 1'b0;
        end else begin
            move_ok      <= 1'b0;
            move_blocked <= 1'b0;
            // A fresh edge on the direction just granted re-arms it.
            pend_reg     <= (pend_reg & ~clr_mask) | rise;

            case (state_reg)
                IDLE: begin
                    if (frame_tick && (|pend_reg)) begin
                        state_reg <= ARB;
                        busy      <= 1'b1;
                    end
                end

                ARB: begin
                    ptr_reg <= dir_t'(grant + 2'd1);
                    if (out_of_bounds) begin
                        move_blocked <= 1'b1;
                        state_reg    <= IDLE;
                        busy         <= 1'b0;
                    end else begin
                        chk_left    <= cand_left[9:0];
                        chk_right   <= cand_right[9:0];
                        chk_top     <= cand_top[9:0];
                        chk_bottom  <= cand_bottom[9:0];
                        chk_valid   <= 1'b1;
                        tmo_cnt_reg <= '0;
                        state_reg   <= CHECK;
                    end
                end

                CHECK: begin
                    if (chk_done && chk_ok) begin
                        sq_left    <= chk_left;
                        sq_right   <= chk_right;
                        sq_top     <= chk_top;
                        sq_bottom  <= chk_bottom;
                        move_ok    <= 1'b1;
                        chk_valid  <= 1'b0;
                        state_reg  <= IDLE;
                        busy       <= 1'b0;
                    end else if (chk_done || (tmo_cnt_reg == TW'(CHK_TIMEOUT - 1))) begin
                        chk_left     <= sq_left;
                        chk_right    <= sq_right;
                        chk_top      <= sq_top;
                        chk_bottom   <= sq_bottom;
                        move_blocked <= 1'b1;
                        chk_valid    <= 1'b0;
                        state_reg    <= IDLE;
                        busy         <= 1'b0;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    chk_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Self-checking bench for player_move_ctrl: directed table, corner sequences,
// boundary instances and randomized frames against a position/pending-set model.
module tb_player_move_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       chk_done = 1'b0, chk_ok = 1'b0;
    logic       chk_valid, move_ok, move_blocked, busy;
    logic [9:0] chk_left, chk_right, chk_top, chk_bottom;
    logic [9:0] sq_left, sq_right, sq_top, sq_bottom;

    // Boundary instances: [0] starts at (620,5), [1] at (614,460); checker never answers.
    logic [3:0] a_btn [2];
    logic       a_valid [2];
    logic       a_blk [2];
    logic       a_ok [2];
    logic       a_busy [2];
    logic [9:0] a_rect [2][8];

    int vectors = 0;
    int miscompares = 0;
    int dxs [4] = '{0, 1, 0, -1};
    int dys [4] = '{-1, 0, 1, 0};

    always #5 clk = ~clk;

    player_move_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .chk_valid(chk_valid), .chk_left(chk_left), .chk_right(chk_right),
        .chk_top(chk_top), .chk_bottom(chk_bottom), .chk_done(chk_done), .chk_ok(chk_ok),
        .sq_left(sq_left), .sq_right(sq_right), .sq_top(sq_top), .sq_bottom(sq_bottom),
        .move_ok(move_ok), .move_blocked(move_blocked), .busy(busy)
    );

    player_move_ctrl #(.START_X(620), .START_Y(5)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .btn_up(a_btn[0][0]), .btn_right(a_btn[0][1]), .btn_down(a_btn[0][2]), .btn_left(a_btn[0][3]),
        .chk_valid(a_valid[0]), .chk_left(a_rect[0][0]), .chk_right(a_rect[0][1]),
        .chk_top(a_rect[0][2]), .chk_bottom(a_rect[0][3]), .chk_done(1'b0), .chk_ok(1'b0),
        .sq_left(a_rect[0][4]), .sq_right(a_rect[0][5]), .sq_top(a_rect[0][6]), .sq_bottom(a_rect[0][7]),
        .move_ok(a_ok[0]), .move_blocked(a_blk[0]), .busy(a_busy[0])
    );

    player_move_ctrl #(.START_X(614), .START_Y(460)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick),
        .btn_up(a_btn[1][0]), .btn_right(a_btn[1][1]), .btn_down(a_btn[1][2]), .btn_left(a_btn[1][3]),
        .chk_valid(a_valid[1]), .chk_left(a_rect[1][0]), .chk_right(a_rect[1][1]),
        .chk_top(a_rect[1][2]), .chk_bottom(a_rect[1][3]), .chk_done(1'b0), .chk_ok(1'b0),
        .sq_left(a_rect[1][4]), .sq_right(a_rect[1][5]), .sq_top(a_rect[1][6]), .sq_bottom(a_rect[1][7]),
        .move_ok(a_ok[1]), .move_blocked(a_blk[1]), .busy(a_busy[1])
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        frame_tick = 1'b0;
        chk_done = 1'b0;
        chk_ok = 1'b0;
        {btn_left, btn_down, btn_right, btn_up} = 4'b0000;
        a_btn[0] = 4'b0000;
        a_btn[1] = 4'b0000;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    // mask bits: 0=up 1=right 2=down 3=left
    task automatic press(input logic [3:0] m);
        {btn_left, btn_down, btn_right, btn_up} = m;
        tick();
        {btn_left, btn_down, btn_right, btn_up} = 4'b0000;
        repeat (5) tick();
    endtask

    // One frame: tick, answer the query after lat cycles (99 = never), report outcome.
    // res: 0 nothing, 1 move_ok, 2 move_blocked.
    task automatic run_frame(input bit ok, input int lat, input bit tick_mid,
                             output int res, output bit queried, output int vlat, output int wait_c,
                             output logic [9:0] ql, output logic [9:0] qr,
                             output logic [9:0] qt, output logic [9:0] qb);
        int vc;
        int cv;
        res = 0; queried = 0; vlat = -1; wait_c = -1;
        ql = '0; qr = '0; qt = '0; qb = '0;
        vc = 0; cv = 0;
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (move_ok || move_blocked) begin
                res = move_ok ? 1 : 2;
                wait_c = c - cv;
                break;
            end
            frame_tick = 1'b0;
            chk_done = 1'b0;
            if (chk_valid) begin
                if (!queried) begin
                    queried = 1; cv = c; vlat = c;
                    ql = chk_left; qr = chk_right; qt = chk_top; qb = chk_bottom;
                end
                if (vc == lat) begin
                    chk_done = 1'b1;
                    chk_ok = ok;
                end
                if (tick_mid && vc == 3) frame_tick = 1'b1;
                vc++;
            end
            tick();
        end
        chk_done = 1'b0;
        frame_tick = 1'b0;
        if (res != 0) begin
            tick();
            check("pulse_once", {move_ok, move_blocked}, 0);
        end
        $display("frame: res=%0d queried=%0d sq=(%0d,%0d,%0d,%0d)",
                 res, queried, sq_left, sq_right, sq_top, sq_bottom);
    endtask

    task automatic aux_frame(input int k, input logic [3:0] m,
                             output bit sv, output bit sb, output logic [9:0] cr);
        a_btn[k] = m;
        tick();
        a_btn[k] = 4'b0000;
        repeat (5) tick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        sv = 0; sb = 0; cr = '0;
        for (int c = 0; c < 25; c++) begin
            if (a_valid[k]) begin
                sv = 1;
                cr = a_rect[k][1];
            end
            if (a_blk[k]) sb = 1;
            tick();
        end
        $display("aux%0d: mask=%b valid_seen=%0d blocked_seen=%0d", k, m, sv, sb);
    endtask

    typedef struct {
        int dir;
        bit ok;
        int lat;
        int exp_res;
        bit exp_q;
        int exp_l;
        int exp_t;
    } vec_t;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        vec_t tbl [14];
        int res, vlat, wait_c;
        bit q, sv, sb;
        logic [9:0] ql, qr, qt, qb, cr;
        int cur_l, cur_t;
        int mx, my, mptr, d, nx, ny, er, lat;
        bit eq, ok;
        logic [3:0] mpend, m;

        tbl[0]  = '{1, 1, 1, 1, 1, 65, 55};
        tbl[1]  = '{0, 0, 0, 2, 1, 65, 55};
        tbl[2]  = '{2, 1, 0, 1, 1, 65, 65};
        tbl[3]  = '{3, 1, 2, 1, 1, 55, 65};
        tbl[4]  = '{0, 1, 0, 1, 1, 55, 55};
        tbl[5]  = '{0, 1, 3, 1, 1, 55, 45};
        tbl[6]  = '{0, 1, 0, 1, 1, 55, 35};
        tbl[7]  = '{0, 1, 0, 1, 1, 55, 25};
        tbl[8]  = '{0, 1, 1, 1, 1, 55, 15};
        tbl[9]  = '{0, 1, 0, 1, 1, 55, 5};
        tbl[10] = '{0, 1, 0, 2, 0, 55, 5};
        tbl[11] = '{3, 1, 99, 2, 1, 55, 5};
        tbl[12] = '{3, 1, 0, 1, 1, 45, 5};
        tbl[13] = '{1, 0, 1, 2, 1, 45, 5};

        a_btn[0] = 4'b0000;
        a_btn[1] = 4'b0000;
        do_reset();

        // Reset state
        check("rst_sq_left", sq_left, 55);
        check("rst_sq_right", sq_right, 70);
        check("rst_sq_top", sq_top, 55);
        check("rst_sq_bottom", sq_bottom, 70);
        check("rst_chk_valid", chk_valid, 0);
        check("rst_chk_left", chk_left, 55);
        check("rst_busy", busy, 0);
        check("rst_move_ok", move_ok, 0);

        // Directed single-direction table
        cur_l = 55; cur_t = 55;
        for (int i = 0; i < 14; i++) begin
            press(4'b0001 << tbl[i].dir);
            run_frame(tbl[i].ok, tbl[i].lat, 0, res, q, vlat, wait_c, ql, qr, qt, qb);
            check($sformatf("tbl%0d_res", i), res, tbl[i].exp_res);
            check($sformatf("tbl%0d_queried", i), q, tbl[i].exp_q);
            check($sformatf("tbl%0d_sq_left", i), sq_left, tbl[i].exp_l);
            check($sformatf("tbl%0d_sq_right", i), sq_right, tbl[i].exp_l + 15);
            check($sformatf("tbl%0d_sq_top", i), sq_top, tbl[i].exp_t);
            check($sformatf("tbl%0d_sq_bottom", i), sq_bottom, tbl[i].exp_t + 15);
            check($sformatf("tbl%0d_busy", i), busy, 0);
            if (tbl[i].exp_q) begin
                check($sformatf("tbl%0d_chk_left", i), ql, cur_l + 10 * dxs[tbl[i].dir]);
                check($sformatf("tbl%0d_chk_right", i), qr, cur_l + 10 * dxs[tbl[i].dir] + 15);
                check($sformatf("tbl%0d_chk_top", i), qt, cur_t + 10 * dys[tbl[i].dir]);
                check($sformatf("tbl%0d_chk_bottom", i), qb, cur_t + 10 * dys[tbl[i].dir] + 15);
                check($sformatf("tbl%0d_valid_latency", i), vlat, 1);
                if (tbl[i].lat != 99)
                    check($sformatf("tbl%0d_answer_latency", i), wait_c, tbl[i].lat + 1);
            end
            cur_l = tbl[i].exp_l;
            cur_t = tbl[i].exp_t;
        end

        // Screen-bound corners on the offset instances
        aux_frame(0, 4'b0001, sv, sb, cr);
        check("auxA_up_no_query", sv, 0);
        check("auxA_up_blocked", sb, 1);
        aux_frame(0, 4'b0010, sv, sb, cr);
        check("auxA_right_no_query", sv, 0);
        check("auxA_right_blocked", sb, 1);
        aux_frame(0, 4'b1000, sv, sb, cr);
        check("auxA_left_query", sv, 1);
        check("auxA_left_chk_right", cr, 625);
        check("auxA_left_timeout", sb, 1);
        aux_frame(1, 4'b0100, sv, sb, cr);
        check("auxB_down_no_query", sv, 0);
        check("auxB_down_blocked", sb, 1);
        aux_frame(1, 4'b0010, sv, sb, cr);
        check("auxB_right_edge_query", sv, 1);
        check("auxB_right_chk_right", cr, 639);
        check("auxB_sq_right", a_rect[1][5], 629);

        // Simultaneous up+right: round-robin from UP, one move per frame
        do_reset();
        press(4'b0011);
        run_frame(1, 0, 0, res, q, vlat, wait_c, ql, qr, qt, qb);
        check("rr1_res", res, 1);
        check("rr1_top", sq_top, 45);
        check("rr1_left", sq_left, 55);
        run_frame(1, 0, 0, res, q, vlat, wait_c, ql, qr, qt, qb);
        check("rr2_res", res, 1);
        check("rr2_left", sq_left, 65);
        run_frame(1, 0, 0, res, q, vlat, wait_c, ql, qr, qt, qb);
        check("rr3_idle", res, 0);
        check("rr3_queried", q, 0);
        check("rr3_top", sq_top, 45);

        // Timeout with a frame_tick during CHECK; down stays pending
        do_reset();
        press(4'b0101);
        run_frame(1, 99, 1, res, q, vlat, wait_c, ql, qr, qt, qb);
        check("tmo_res", res, 2);
        check("tmo_cycles", wait_c, 15);
        check("tmo_top", sq_top, 55);
        repeat (3) tick();
        check("tmo_busy_after", busy, 0);
        run_frame(1, 0, 0, res, q, vlat, wait_c, ql, qr, qt, qb);
        check("tmo_next_res", res, 1);
        check("tmo_next_top", sq_top, 65);

        // Asynchronous reset during CHECK
        do_reset();
        press(4'b0101);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        for (int c = 0; c < 10 && !chk_valid; c++) tick();
        check("arst_in_check", chk_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_chk_valid", chk_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_sq_left", sq_left, 55);
        check("arst_sq_top", sq_top, 55);
        check("arst_chk_top", chk_top, 55);
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        run_frame(1, 0, 0, res, q, vlat, wait_c, ql, qr, qt, qb);
        check("arst_pend_cleared", res, 0);

        // Randomized frames against the model
        do_reset();
        mx = 55; my = 55; mptr = 0; mpend = 4'b0000;
        for (int r = 0; r < 60; r++) begin
            m = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            if (m != 0) press(m);
            mpend = mpend | m;
            ok = ($urandom_range(0, 3) != 0);
            lat = ($urandom_range(0, 5) == 0) ? 99 : int'($urandom_range(0, 3));
            er = 0; eq = 0; nx = mx; ny = my;
            if (mpend != 0) begin
                d = mptr;
                for (int i = 0; i < 4; i++) begin
                    if (mpend[(mptr + i) % 4]) begin
                        d = (mptr + i) % 4;
                        break;
                    end
                end
                mpend[d] = 1'b0;
                mptr = (d + 1) % 4;
                nx = mx + 10 * dxs[d];
                ny = my + 10 * dys[d];
                if (nx < 0 || ny < 0 || nx + 15 > 639 || ny + 15 > 479) begin
                    er = 2;
                end else begin
                    eq = 1;
                    er = (lat == 99 || !ok) ? 2 : 1;
                end
            end
            run_frame(ok, lat, 0, res, q, vlat, wait_c, ql, qr, qt, qb);
            if (er == 1) begin
                mx = nx;
                my = ny;
            end
            check($sformatf("rnd%0d_res", r), res, er);
            check($sformatf("rnd%0d_queried", r), q, eq);
            check($sformatf("rnd%0d_sq_left", r), sq_left, mx);
            check($sformatf("rnd%0d_sq_top", r), sq_top, my);
            check($sformatf("rnd%0d_sq_right", r), sq_right, mx + 15);
            check($sformatf("rnd%0d_sq_bottom", r), sq_bottom, my + 15);
            if (eq) begin
                check($sformatf("rnd%0d_chk_left", r), ql, nx);
                check($sformatf("rnd%0d_chk_top", r), qt, ny);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
